// File: rtl/alarm_pkg.sv
// alarm_pkg: state encoding and default timing constants shared by
// alarm_responder and its testbench.
package alarm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RINGING = 2'b01,
        ST_SNOOZE  = 2'b10
    } alarm_state_e;

    localparam int DEF_RING_SECONDS   = 60;
    localparam int DEF_SNOOZE_SECONDS = 300;
    localparam int DEF_MAX_SNOOZE     = 3;
    localparam int DEF_BLINK_DIV      = 50;

    // Bits needed to hold the longer of the two intervals, including 0.
    function automatic int timer_width(input int ring_s, input int snooze_s);
        int longest;
        longest = (ring_s > snooze_s) ? ring_s : snooze_s;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/second_timer.sv
// second_timer: seconds down-counter shared by the ring and snooze intervals.
// A load of N pulses expire on the Nth tick after the load; the count stops
// at 0 and never wraps.
module second_timer #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic         expire,
    output logic [W-1:0] count
);

    // Load wins over a same-cycle tick; otherwise count down once per tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (tick && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    // Expiry is the tick that would take the count from 1 to 0.
    assign expire = tick && (count == W'(1));

endmodule

// File: rtl/alarm_responder.sv
// alarm_responder: reacts to the clock core's alarm match -- rings, blinks the
// LED, handles snooze/dismiss and the ring timeout, and records missed alarms.
// Optional snooze support is compiled in when ALARM_SNOOZE_EN is defined;
// without it the SNOOZE state is unreachable and snoozing/snooze_count are 0.
// fsm_state and timer_count are debug views of the FSM and the seconds timer.
module alarm_responder
    import alarm_pkg::*;
#(
    parameter int RING_SECONDS   = DEF_RING_SECONDS,
    parameter int SNOOZE_SECONDS = DEF_SNOOZE_SECONDS,
    parameter int MAX_SNOOZE     = DEF_MAX_SNOOZE,
    parameter int BLINK_DIV      = DEF_BLINK_DIV
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       alarm_hit,
    input  logic       armed,
    input  logic       btn_snooze,
    input  logic       btn_dismiss,
    output logic       ring,
    output logic       led_blink,
    output logic       snoozing,
    output logic [2:0] snooze_count,
    output logic       missed,
    output logic [1:0] fsm_state,
    output logic [timer_width(RING_SECONDS, SNOOZE_SECONDS)-1:0] timer_count
);

    localparam int TW = timer_width(RING_SECONDS, SNOOZE_SECONDS);
    localparam logic [TW-1:0] RING_LOAD = TW'(RING_SECONDS);
    localparam int DIV_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BLINK_DIV - 1);

    alarm_state_e    state, next_state;
    logic            next_missed;
    logic            hit_prev, hit_primed, hit_rise;
    logic            timer_load, timer_expire;
    logic [TW-1:0]   timer_val;
    logic [DIV_W-1:0] blink_div;

`ifdef ALARM_SNOOZE_EN
    localparam logic [TW-1:0] SNOOZE_LOAD  = TW'(SNOOZE_SECONDS);
    localparam logic [2:0]    SNOOZE_LIMIT = 3'(MAX_SNOOZE);
    logic [2:0] snooze_cnt, next_cnt;
`endif

    second_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (timer_val),
        .tick     (tick_1hz),
        .expire   (timer_expire),
        .count    (timer_count)
    );

    // alarm_hit history; the first cycle after reset only primes it so a
    // level already high at reset release is not taken as a new event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_prev   <= 1'b0;
            hit_primed <= 1'b0;
        end else begin
            hit_prev   <= alarm_hit;
            hit_primed <= 1'b1;
        end
    end

    assign hit_rise = hit_primed && alarm_hit && !hit_prev;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and side effects; priority is disarm > dismiss > snooze > expiry.
    always_comb begin
        next_state  = state;
        next_missed = missed;
        timer_load  = 1'b0;
        timer_val   = RING_LOAD;
`ifdef ALARM_SNOOZE_EN
        next_cnt    = snooze_cnt;
`endif
        if (!armed) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (btn_dismiss) begin
                        next_missed = 1'b0;
                    end
                    if (hit_rise) begin
                        next_state = ST_RINGING;
                        timer_load = 1'b1;
                        timer_val  = RING_LOAD;
`ifdef ALARM_SNOOZE_EN
                        next_cnt   = 3'd0;
`endif
                    end
                end
                ST_RINGING: begin
                    if (btn_dismiss) begin
                        next_state  = ST_IDLE;
                        next_missed = 1'b0;
                    end
`ifdef ALARM_SNOOZE_EN
                    else if (btn_snooze && (snooze_cnt < SNOOZE_LIMIT)) begin
                        next_state = ST_SNOOZE;
                        next_cnt   = snooze_cnt + 3'd1;
                        timer_load = 1'b1;
                        timer_val  = SNOOZE_LOAD;
                    end
`endif
                    else if (timer_expire) begin
                        next_state  = ST_IDLE;
                        next_missed = 1'b1;
                    end
                end
`ifdef ALARM_SNOOZE_EN
                ST_SNOOZE: begin
                    if (btn_dismiss) begin
                        next_state  = ST_IDLE;
                        next_missed = 1'b0;
                    end else if (timer_expire) begin
                        next_state = ST_RINGING;
                        timer_load = 1'b1;
                        timer_val  = RING_LOAD;
                    end
                end
`endif
                default: begin
                    next_state = ST_IDLE;
                end
            endcase
        end
    end

    // Registered buzzer and sticky missed flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ring   <= 1'b0;
            missed <= 1'b0;
        end else begin
            ring   <= (next_state == ST_RINGING);
            missed <= next_missed;
        end
    end

    // LED blink: starts lit on RINGING entry, toggles every BLINK_DIV clocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_blink <= 1'b0;
            blink_div <= '0;
        end else if (next_state != ST_RINGING) begin
            led_blink <= 1'b0;
            blink_div <= '0;
        end else if (state != ST_RINGING) begin
            led_blink <= 1'b1;
            blink_div <= '0;
        end else if (blink_div == DIV_LAST) begin
            led_blink <= ~led_blink;
            blink_div <= '0;
        end else begin
            blink_div <= blink_div + DIV_W'(1);
        end
    end

`ifdef ALARM_SNOOZE_EN
    // Registered snooze indicator and per-event snooze count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snoozing   <= 1'b0;
            snooze_cnt <= 3'd0;
        end else begin
            snoozing   <= (next_state == ST_SNOOZE);
            snooze_cnt <= next_cnt;
        end
    end

    assign snooze_count = snooze_cnt;
`else
    // Snooze support compiled out: the button and limit have no effect.
    logic [3:0] unused_snooze;
    assign unused_snooze = {btn_snooze, 3'(MAX_SNOOZE)};
    assign snoozing      = 1'b0;
    assign snooze_count  = 3'd0;
`endif

    assign fsm_state = state;

endmodule
